// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one data-cache transaction per load/store,
// stalls upstream until the ack, then writes the selected result into MEM/WB.
module mem_stage #(
    parameter int REG_SIZE  = 32,
    parameter int ADDR_SIZE = 32,
    parameter int REG_ADDR  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_SIZE-1:0]  alu_result_in,
    input  logic [REG_SIZE-1:0]  data_store_in,
    input  logic                 do_read_in,
    input  logic                 do_write_in,
    input  logic                 is_byte_in,
    input  logic                 memtoreg_in,
    input  logic                 regwrite_in,
    input  logic [REG_ADDR-1:0]  dst_reg_in,
    output logic                 dc_req,
    output logic                 dc_we,
    output logic [ADDR_SIZE-1:0] dc_addr,
    output logic [REG_SIZE-1:0]  dc_wdata,
    output logic [3:0]           dc_be,
    input  logic                 dc_ack,
    input  logic [REG_SIZE-1:0]  dc_rdata,
    output logic                 stall,
    output logic [REG_SIZE-1:0]  mem_forward,
    output logic                 wb_regwrite,
    output logic [REG_ADDR-1:0]  wb_dst_reg,
    output logic [REG_SIZE-1:0]  wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state;
    logic                   acc;
    logic [1:0]             lane;
    logic [ADDR_SIZE-1:0]   addr_full;
    logic [ADDR_SIZE-1:0]   addr_aligned;
    logic [REG_SIZE-1:0]    ld_buf_p1;
    logic [REG_SIZE-1:0]    ld_fmt;
    logic [REG_SIZE-1:0]    result;

    function automatic logic [3:0] lane_mask(input logic byte_acc, input logic [1:0] sel);
        return byte_acc ? (4'b0001 << sel) : 4'hF;
    endfunction

    function automatic logic [REG_SIZE-1:0] store_data(input logic byte_acc,
                                                       input logic [REG_SIZE-1:0] d);
        return byte_acc ? {(REG_SIZE/8){d[7:0]}} : d;
    endfunction

    // Byte loads return the addressed little-endian lane, sign-extended.
    function automatic logic [REG_SIZE-1:0] load_format(input logic byte_acc,
                                                        input logic [1:0] sel,
                                                        input logic [REG_SIZE-1:0] word);
        logic signed [7:0]          b;
        logic signed [REG_SIZE-1:0] ext;
        b   = word[{sel, 3'b000} +: 8];
        ext = REG_SIZE'(b);
        return byte_acc ? ext : word;
    endfunction

    assign acc          = do_read_in | do_write_in;
    assign lane         = alu_result_in[1:0];
    assign addr_full    = ADDR_SIZE'(alu_result_in);
    assign addr_aligned = {addr_full[ADDR_SIZE-1:2], 2'b00};
    assign mem_forward  = alu_result_in;
    assign ld_fmt       = load_format(is_byte_in, lane, ld_buf_p1);
    assign result       = memtoreg_in ? ld_fmt : alu_result_in;

    // Gated by reset so upstream is released the moment a transaction is abandoned.
    assign stall = ~reset & (((state == IDLE) & acc) | (state == WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            dc_req      <= 1'b0;
            dc_we       <= 1'b0;
            dc_addr     <= '0;
            dc_wdata    <= '0;
            dc_be       <= 4'h0;
            ld_buf_p1   <= '0;
            wb_regwrite <= 1'b0;
            wb_dst_reg  <= '0;
            wb_data     <= '0;
        end else begin
            // Cache transaction: issue, wait for ack, then hold until MEM/WB takes it
            case (state)
                IDLE: begin
                    if (acc) begin
                        dc_req   <= 1'b1;
                        dc_we    <= do_write_in;
                        dc_addr  <= addr_aligned;
                        dc_be    <= lane_mask(is_byte_in, lane);
                        dc_wdata <= do_write_in ? store_data(is_byte_in, data_store_in) : '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (dc_ack) begin
                        dc_req <= 1'b0;
                        if (!dc_we) begin
                            ld_buf_p1 <= dc_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (we) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // MEM/WB register: bubble while stalled, capture when the result is ready
            if (we) begin
                if (stall) begin
                    wb_regwrite <= 1'b0;
                    wb_dst_reg  <= '0;
                    wb_data     <= '0;
                end else begin
                    wb_regwrite <= regwrite_in;
                    wb_dst_reg  <= dst_reg_in;
                    wb_data     <= result;
                end
            end
        end
    end

endmodule
